alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front-end loader between board switches/buttons and the ALU.
//  - Conditions raw buttons: synchroniser, debounce and rising-edge detection.
//  - Captures operand A, operand B and the opcode from i_switches.
//  - Two load modes: direct (one button per register) and sequential (one STEP button walks A->B->OP).
//  - Presents a valid/ready handshake so the ALU consumes each operand set exactly once.
// PARAMETERS
//  NB_DATA        8   operand width (switch bus width)
//  NB_OP          6   opcode width; taken from i_switches[NB_OP-1:0]
//  NB_SYNC        2   synchroniser flip-flop stages per button (>=2)
//  DEBOUNCE_CYC   16  consecutive stable cycles needed before the debounced level changes (>=1)
//  NB_DBC_CNT     5   debounce counter width; must hold DEBOUNCE_CYC
// PORTS
//  i_clock      in   1        single system clock, rising edge
//  i_reset      in   1        asynchronous, active-low reset
//  i_switches   in   NB_DATA  signed data/opcode source, asynchronous to clock
//  i_buttons    in   3        direct load buttons: [0]=A, [1]=B, [2]=OP; raw, asynchronous
//  i_btn_step   in   1        sequential-mode step button; raw, asynchronous
//  i_mode       in   1        0=direct, 1=sequential; quasi-static
//  i_ready      in   1        consumer accepts the operand set
//  o_data_a     out  NB_DATA  signed operand A
//  o_data_b     out  NB_DATA  signed operand B
//  o_operation  out  NB_OP    opcode
//  o_valid      out  1        full operand set is present and not yet consumed
//  o_loaded     out  3        per-register loaded flags {OP,B,A} for LEDs
// BEHAVIOUR
//  - Reset (i_reset=0, asynchronous) forces:
//      o_data_a=0, o_data_b=0, o_operation=0, o_valid=0, o_loaded=0;
//      FSM=S_A; synchroniser and debounce state=0.
//  - Button conditioning, per button:
//      - NB_SYNC-stage synchroniser.
//      - Debounced level toggles once the synchronised level differs from it for DEBOUNCE_CYC consecutive cycles; any mismatch gap clears the counter.
//      - 1-cycle press pulse on a debounced 0->1 transition only; releases produce no pulse.
//  - Latency: the register updates NB_SYNC+DEBOUNCE_CYC+1 clocks after the raw rising edge.
//      - Value captured = i_switches sampled in the pulse cycle.
//      - i_switches is not synchronised; operator holds switches stable.
//  - Direct mode (i_mode=0):
//      - Pulse on button k loads register k and sets o_loaded[k]; i_btn_step ignored.
//      - Simultaneous pulses load every pressed register in the same cycle.
//  - Sequential mode (i_mode=1), FSM S_A -> S_B -> S_OP -> S_VALID; each step pulse loads the current register and advances.
//      - i_buttons are ignored in this mode.
//      - Step pulses in S_VALID are ignored.
//      - Handshake in S_VALID returns the FSM to S_A.
//  - Validity and handshake:
//      - o_valid = &o_loaded (registered).
//      - Transfer when o_valid & i_ready: o_loaded cleared next cycle, so o_valid drops.
//      - Data registers keep their values after transfer.
//      - i_ready while !o_valid has no effect.
//      - Load pulse in the same cycle as a transfer: register loads and its flag ends set (load wins for that flag only).
//      - Reloading a register while o_valid=1 (direct mode) updates data; o_valid stays 1.
//  - Mode change (i_mode differs from its 1-cycle delayed copy):
//      - Clears o_loaded and o_valid; FSM goes to S_A; data registers keep their values.
//      - Any load pulse in that cycle is discarded.
//  - Reset asserted mid-debounce or mid-sequence: all state lost; no pulse after release unless the button is re-pressed (debounced level starts at 0).
// STRUCTURE
//  - Package alu_operand_pkg:
//      - FSM state localparams S_A=2'd0, S_B=2'd1, S_OP=2'd2, S_VALID=2'd3.
//      - Load-index constants IDX_A=0, IDX_B=1, IDX_OP=2.
//      - Mode constants MODE_DIRECT=0, MODE_SEQ=1.
//  - Sub-module button_conditioner (params NB_SYNC, DEBOUNCE_CYC, NB_DBC_CNT):
//      - Ports i_clock, i_reset, i_button -> o_level, o_press.
//      - 4 instances: 3 direct buttons + step.
//  - Top level: loader registers, loaded flags, sequencing FSM, handshake logic.
// TESTING (DEBOUNCE_CYC=4, NB_SYNC=2 for sim)
//  1. Reset check: assert i_reset=0 mid-run -> all outputs 0 immediately; hold after release with no presses -> outputs stay 0.
//  2. Direct load:
//     - mode=0, switches=8'hF6, press A 10 cycles -> o_data_a=-10 exactly 7 clocks after the edge, o_loaded=3'b001.
//     - Then B=8'h03, OP=6'h20 -> o_valid=1.
//  3. Bounce rejection: A toggles 1/0 every 2 cycles for 20 cycles, then held 1 -> exactly one load, using switches at the settle point.
//  4. Sequential mode: mode=1, three step presses with switches 5, 7, 6'h22:
//     - A=5, B=7, OP=6'h22, o_valid=1.
//     - A 4th press changes nothing.
//     - i_ready pulse -> o_valid=0 next cycle, FSM back to S_A, data held.
//  5. Simultaneous events:
//     - Load-A pulse coincident with transfer -> o_loaded=3'b001 afterwards.
//     - All three direct buttons pressed together -> all load in one cycle.
//  6. Mode switch at o_valid=1 -> o_valid=0 and o_loaded=0 next cycle; data unchanged.

Source files
------------

// File: rtl/alu_operand_pkg.sv
// alu_operand_pkg: shared constants for the ALU operand sequencer
package alu_operand_pkg;
    localparam logic [1:0] S_A     = 2'd0;
    localparam logic [1:0] S_B     = 2'd1;
    localparam logic [1:0] S_OP    = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam int IDX_A  = 0;
    localparam int IDX_B  = 1;
    localparam int IDX_OP = 2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SEQ    = 1'b1;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces a raw button, emitting a one-cycle press pulse
module button_conditioner #(
    parameter int NB_SYNC      = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int NB_DBC_CNT   = 5
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_level,
    output logic o_press
);
    logic [NB_SYNC-1:0]    sync_q;
    logic [NB_DBC_CNT-1:0] cnt_q, cnt_d;
    logic                  level_q, level_d, level_prev_q;
    logic                  mismatch, done;

    assign mismatch = sync_q[NB_SYNC-1] != level_q;
    assign done     = cnt_q == NB_DBC_CNT'(DEBOUNCE_CYC - 1);

    // The counter only runs while the synchronised input disagrees; any agreeing cycle restarts it.
    always_comb begin
        level_d = (mismatch && done) ? ~level_q : level_q;
        cnt_d   = (mismatch && !done) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[NB_SYNC-2:0], i_button};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign o_level = level_q;
    assign o_press = level_q & ~level_prev_q;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads ALU operands/opcode from switches via direct or stepped
// button presses and hands each complete set to the ALU exactly once
module alu_operand_sequencer
    import alu_operand_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int NB_OP        = 6,
    parameter int NB_SYNC      = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int NB_DBC_CNT   = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic signed [NB_DATA-1:0] i_switches,
    input  logic [2:0]                i_buttons,
    input  logic                      i_btn_step,
    input  logic                      i_mode,
    input  logic                      i_ready,
    output logic signed [NB_DATA-1:0] o_data_a,
    output logic signed [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]          o_operation,
    output logic                      o_valid,
    output logic [2:0]                o_loaded
);
    logic [3:0]                raw, press;
    logic [2:0]                ld, seq_ld, loaded_q, loaded_d;
    logic [1:0]                state_q, state_d;
    logic signed [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]          op_q;
    logic                      mode_q, mode_chg, xfer, seq;

    assign raw = {i_btn_step, i_buttons};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_conditioner #(
            .NB_SYNC     (NB_SYNC),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .NB_DBC_CNT  (NB_DBC_CNT)
        ) u_btn (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_button(raw[i]),
            .o_level (),
            .o_press (press[i])
        );
    end

    // A mode change discards any coincident load and restarts the sequence.
    always_comb begin
        seq      = i_mode == MODE_SEQ;
        mode_chg = i_mode != mode_q;
        xfer     = o_valid & i_ready;
        seq_ld   = {3{press[3]}} & {state_q == S_OP, state_q == S_B, state_q == S_A};
        ld       = mode_chg ? 3'b000 : (seq ? seq_ld : press[2:0]);
        loaded_d = mode_chg ? 3'b000 : ((xfer ? 3'b000 : loaded_q) | ld);
        state_d  = (mode_chg || (xfer && state_q == S_VALID)) ? S_A :
                   (seq && |ld) ? state_q + 2'd1 : state_q;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            loaded_q <= '0;
            state_q  <= S_A;
            mode_q   <= MODE_DIRECT;
        end else begin
            if (ld[IDX_A])  a_q  <= i_switches;
            if (ld[IDX_B])  b_q  <= i_switches;
            if (ld[IDX_OP]) op_q <= i_switches[NB_OP-1:0];
            loaded_q <= loaded_d;
            state_q  <= state_d;
            mode_q   <= i_mode;
        end
    end

    assign o_data_a    = a_q;
    assign o_data_b    = b_q;
    assign o_operation = op_q;
    assign o_loaded    = loaded_q;
    assign o_valid     = &loaded_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed scenario checks of the operand sequencer
module tb_alu_operand_sequencer;
    logic       clk, rst_n;
    logic [7:0] sw;
    logic [2:0] btn, loaded;
    logic       step, mode, ready, valid;
    logic [7:0] da, db;
    logic [5:0] op;
    int total = 0;
    int bad   = 0;

    alu_operand_sequencer #(
        .NB_DATA(8), .NB_OP(6), .NB_SYNC(2), .DEBOUNCE_CYC(4), .NB_DBC_CNT(5)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_switches(sw), .i_buttons(btn),
        .i_btn_step(step), .i_mode(mode), .i_ready(ready),
        .o_data_a(da), .o_data_b(db), .o_operation(op),
        .o_valid(valid), .o_loaded(loaded)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0; btn = 0; step = 0; mode = 0; ready = 0; sw = 0;
        cyc(3);
        total++; if ({da, db, op, valid, loaded} !== 26'd0) begin bad++; $display("FAIL reset_init: got %h expected 0", {da, db, op, valid, loaded}); end
        rst_n = 1; sw = 8'h11; btn[0] = 1;
        cyc(7);
        total++; if (da !== 8'h11 || loaded !== 3'b001) begin bad++; $display("FAIL pre_reset_load: got a=%h ld=%b expected a=11 ld=001", da, loaded); end
        #3 rst_n = 0;
        #1;
        total++; if ({da, db, op, valid, loaded} !== 26'd0) begin bad++; $display("FAIL async_reset: got %h expected 0", {da, db, op, valid, loaded}); end
        btn[0] = 0;
        cyc(1);
        rst_n = 1; btn[1] = 1;
        cyc(3);
        rst_n = 0; btn[1] = 0;
        cyc(2);
        rst_n = 1;
        cyc(20);
        total++; if ({da, db, op, valid, loaded} !== 26'd0) begin bad++; $display("FAIL post_reset_idle: got %h expected 0", {da, db, op, valid, loaded}); end
    endtask

    task automatic test_direct_load;
        sw = 8'hF6; btn[0] = 1;
        cyc(6);
        total++; if (da !== 8'h00 || loaded !== 3'b000) begin bad++; $display("FAIL a_latency_early: got a=%h ld=%b expected a=00 ld=000", da, loaded); end
        cyc(1);
        total++; if (da !== 8'hF6 || loaded !== 3'b001 || valid !== 1'b0) begin bad++; $display("FAIL a_load: got a=%h ld=%b v=%b expected a=f6 ld=001 v=0", da, loaded, valid); end
        cyc(3); btn[0] = 0; cyc(10);
        sw = 8'h03; btn[1] = 1; cyc(10); btn[1] = 0; cyc(10);
        sw = 8'h20; btn[2] = 1; cyc(10); btn[2] = 0; cyc(10);
        total++; if (db !== 8'h03 || op !== 6'h20) begin bad++; $display("FAIL b_op_load: got b=%h op=%h expected b=03 op=20", db, op); end
        total++; if (valid !== 1'b1 || loaded !== 3'b111) begin bad++; $display("FAIL direct_valid: got v=%b ld=%b expected v=1 ld=111", valid, loaded); end
    endtask

    task automatic test_bounce;
        sw = 8'h40;
        for (int i = 0; i < 10; i++) begin
            btn[0] = (i % 2 == 0);
            cyc(2);
        end
        total++; if (da !== 8'hF6) begin bad++; $display("FAIL bounce_no_load: got a=%h expected f6", da); end
        sw = 8'h5A; btn[0] = 1;
        cyc(6);
        total++; if (da !== 8'hF6) begin bad++; $display("FAIL bounce_early: got a=%h expected f6", da); end
        cyc(1);
        total++; if (da !== 8'h5A || valid !== 1'b1) begin bad++; $display("FAIL bounce_settle: got a=%h v=%b expected a=5a v=1", da, valid); end
        sw = 8'h77;
        cyc(10);
        total++; if (da !== 8'h5A) begin bad++; $display("FAIL bounce_single: got a=%h expected 5a", da); end
        btn[0] = 0; cyc(10);
    endtask

    task automatic test_sequential;
        mode = 1;
        cyc(1);
        total++; if (valid !== 1'b0 || loaded !== 3'b000 || da !== 8'h5A) begin bad++; $display("FAIL mode_to_seq: got v=%b ld=%b a=%h expected v=0 ld=000 a=5a", valid, loaded, da); end
        sw = 8'h05; step = 1; cyc(10); step = 0; cyc(10);
        sw = 8'h07; step = 1; cyc(10); step = 0; cyc(10);
        sw = 8'h22; step = 1; cyc(10); step = 0; cyc(10);
        total++; if (da !== 8'h05 || db !== 8'h07 || op !== 6'h22 || valid !== 1'b1) begin bad++; $display("FAIL seq_load: got a=%h b=%h op=%h v=%b expected 05 07 22 1", da, db, op, valid); end
        sw = 8'h99; step = 1; cyc(10); step = 0; cyc(10);
        total++; if (da !== 8'h05 || db !== 8'h07 || op !== 6'h22 || loaded !== 3'b111) begin bad++; $display("FAIL seq_extra_step: got a=%h b=%h op=%h ld=%b expected 05 07 22 111", da, db, op, loaded); end
        ready = 1; cyc(1); ready = 0;
        total++; if (valid !== 1'b0 || loaded !== 3'b000 || da !== 8'h05 || op !== 6'h22) begin bad++; $display("FAIL seq_xfer: got v=%b ld=%b a=%h op=%h expected 0 000 05 22", valid, loaded, da, op); end
        sw = 8'h0C; step = 1; cyc(10); step = 0; cyc(10);
        total++; if (da !== 8'h0C || loaded !== 3'b001) begin bad++; $display("FAIL seq_restart: got a=%h ld=%b expected a=0c ld=001", da, loaded); end
        sw = 8'h33; btn[1] = 1; cyc(10); btn[1] = 0; cyc(10);
        total++; if (db !== 8'h07 || loaded !== 3'b001) begin bad++; $display("FAIL seq_ignore_btn: got b=%h ld=%b expected b=07 ld=001", db, loaded); end
    endtask

    task automatic test_simultaneous;
        mode = 0;
        cyc(1);
        total++; if (loaded !== 3'b000) begin bad++; $display("FAIL mode_to_direct: got ld=%b expected 000", loaded); end
        sw = 8'h2B; btn = 3'b111;
        cyc(6);
        total++; if (loaded !== 3'b000) begin bad++; $display("FAIL all_early: got ld=%b expected 000", loaded); end
        cyc(1);
        total++; if (da !== 8'h2B || db !== 8'h2B || op !== 6'h2B || loaded !== 3'b111) begin bad++; $display("FAIL all_load: got a=%h b=%h op=%h ld=%b expected 2b 2b 2b 111", da, db, op, loaded); end
        btn = 3'b000; cyc(10);
        sw = 8'h01; btn[0] = 1;
        cyc(6);
        ready = 1; cyc(1); ready = 0;
        total++; if (loaded !== 3'b001 || da !== 8'h01 || valid !== 1'b0) begin bad++; $display("FAIL load_wins: got ld=%b a=%h v=%b expected 001 01 0", loaded, da, valid); end
        btn[0] = 0; cyc(10);
        ready = 1; cyc(2); ready = 0;
        total++; if (loaded !== 3'b001) begin bad++; $display("FAIL ready_idle: got ld=%b expected 001", loaded); end
    endtask

    task automatic test_mode_switch;
        sw = 8'h10; btn = 3'b110;
        cyc(7);
        total++; if (valid !== 1'b1 || loaded !== 3'b111) begin bad++; $display("FAIL pre_switch: got v=%b ld=%b expected 1 111", valid, loaded); end
        btn = 3'b000; cyc(10);
        mode = 1;
        cyc(1);
        total++; if (valid !== 1'b0 || loaded !== 3'b000) begin bad++; $display("FAIL switch_clear: got v=%b ld=%b expected 0 000", valid, loaded); end
        total++; if (da !== 8'h01 || db !== 8'h10 || op !== 6'h10) begin bad++; $display("FAIL switch_hold: got a=%h b=%h op=%h expected 01 10 10", da, db, op); end
    endtask

    initial begin
        test_reset;
        test_direct_load;
        test_bounce;
        test_sequential;
        test_simultaneous;
        test_mode_switch;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
